// File: rtl/alu_result_stage.sv
// Registered result stage behind the 64-bit logical units: 2-entry skid buffer with capture-time flags.
// Optional per-entry parity storage is enabled by defining ALU_RESULT_STAGE_PARITY_EN.
module alu_result_stage #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [1:0]       out_op,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_parity,
   output logic             err_op,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   occ_t             occ;
   logic             rd_ptr;
   logic             wr_ptr;
   logic [WIDTH-1:0] mem_result [2];
   logic [1:0]       mem_op     [2];
   logic             mem_zero   [2];
   logic             mem_neg    [2];
   logic             push;
   logic             pop;
   logic             drop;

   // Handshake terms depend on registered occupancy only, never on out_ready.
   assign in_ready  = (occ != OCC_FULL);
   assign out_valid = (occ != OCC_EMPTY);
   assign push      = in_valid && in_ready && (in_op != 2'b11);
   assign drop      = in_valid && in_ready && (in_op == 2'b11);
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ           <= OCC_EMPTY;
         rd_ptr        <= 1'b0;
         wr_ptr        <= 1'b0;
         err_op        <= 1'b0;
         retired       <= '0;
         mem_result[0] <= '0;
         mem_result[1] <= '0;
         mem_op[0]     <= '0;
         mem_op[1]     <= '0;
         mem_zero[0]   <= 1'b0;
         mem_zero[1]   <= 1'b0;
         mem_neg[0]    <= 1'b0;
         mem_neg[1]    <= 1'b0;
      end else begin
         if (push) begin
            mem_result[wr_ptr] <= in_result;
            mem_op[wr_ptr]     <= in_op;
            mem_zero[wr_ptr]   <= (in_result == '0);
            mem_neg[wr_ptr]    <= in_result[WIDTH-1];
            wr_ptr             <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr  <= ~rd_ptr;
            retired <= retired + CNT_W'(1);
         end
         if (drop) begin
            err_op <= 1'b1;
         end
         case ({push, pop})
            2'b10:   occ <= (occ == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
            2'b01:   occ <= (occ == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
            default: occ <= occ;
         endcase
      end
   end

   assign out_result = mem_result[rd_ptr];
   assign out_op     = mem_op[rd_ptr];
   assign out_zero   = mem_zero[rd_ptr];
   assign out_neg    = mem_neg[rd_ptr];

`ifdef ALU_RESULT_STAGE_PARITY_EN
   logic mem_par [2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_par[0] <= 1'b0;
         mem_par[1] <= 1'b0;
      end else if (push) begin
         mem_par[wr_ptr] <= ^in_result;
      end
   end

   assign out_parity = mem_par[rd_ptr];
`else
   assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model, per-cycle compare, directed literal pins.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in_result;
   logic [1:0]  in_op;
   logic        out_ready;

   logic        in_ready, out_valid, out_zero, out_neg, out_parity, err_op;
   logic [63:0] out_result;
   logic [1:0]  out_op;
   logic [15:0] retired;

   logic        in_ready_4, out_valid_4, out_zero_4, out_neg_4, out_parity_4, err_op_4;
   logic [63:0] out_result_4;
   logic [1:0]  out_op_4;
   logic [3:0]  retired_4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_result_stage #(.WIDTH(64), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_op(out_op), .out_zero(out_zero), .out_neg(out_neg),
      .out_parity(out_parity), .err_op(err_op), .retired(retired)
   );

   alu_result_stage #(.WIDTH(64), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
      .in_result(in_result), .in_op(in_op), .out_valid(out_valid_4), .out_ready(out_ready),
      .out_result(out_result_4), .out_op(out_op_4), .out_zero(out_zero_4), .out_neg(out_neg_4),
      .out_parity(out_parity_4), .err_op(err_op_4), .retired(retired_4)
   );

   typedef struct {
      logic [63:0] r;
      logic [1:0]  op;
   } ent_t;

   ent_t        q[$];
   bit          m_err;
   int unsigned m_retired;

   function automatic logic exp_par(input logic [63:0] r);
`ifdef ALU_RESULT_STAGE_PARITY_EN
      return ^r;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO of accepted transactions, updated on each clock edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_err     = 1'b0;
         m_retired = 0;
      end else begin
         bit can_in, can_pop, do_push;
         ent_t e;
         can_in  = (q.size() < 2);
         can_pop = (q.size() != 0) && out_ready;
         do_push = in_valid && can_in && (in_op != 2'b11);
         if (in_valid && can_in && in_op == 2'b11) m_err = 1'b1;
         if (can_pop) begin
            void'(q.pop_front());
            m_retired++;
         end
         if (do_push) begin
            e.r  = in_result;
            e.op = in_op;
            q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_in_ready", 64'(in_ready), 64'd1);
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_out_result", out_result, 64'd0);
         chk("rst_flags", 64'({out_op, out_zero, out_neg, out_parity, err_op}), 64'd0);
         chk("rst_retired", 64'(retired), 64'd0);
      end else begin
         chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("err_op", 64'(err_op), 64'(m_err));
         chk("retired", 64'(retired), 64'(m_retired[15:0]));
         chk("retired_4", 64'(retired_4), 64'(m_retired[3:0]));
         chk("out_valid_4", 64'(out_valid_4), 64'(q.size() != 0));
         if (q.size() != 0) begin
            chk("out_result", out_result, q[0].r);
            chk("out_op", 64'(out_op), 64'(q[0].op));
            chk("out_zero", 64'(out_zero), 64'(q[0].r == 64'd0));
            chk("out_neg", 64'(out_neg), 64'(q[0].r[63]));
            chk("out_parity", 64'(out_parity), 64'(exp_par(q[0].r)));
            chk("out_result_4", out_result_4, q[0].r);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [63:0] r, input logic [1:0] op);
      in_valid  = 1'b1;
      in_result = r;
      in_op     = op;
   endtask

   initial begin
      logic [63:0] a;
      logic [15:0] r0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_result = '0;
      in_op     = 2'b00;
      out_ready = 1'b0;
      #2;
      chk("init_in_ready", 64'(in_ready), 64'd1);
      chk("init_out_valid", 64'(out_valid), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // XOR pass-through of all ones
      out_ready = 1'b1;
      r0 = retired;
      offer(64'hFFFF_FFFF_FFFF_FFFF, 2'b10);
      step();
      in_valid = 1'b0;
      chk("xor_valid", 64'(out_valid), 64'd1);
      chk("xor_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("xor_zero", 64'(out_zero), 64'd0);
      chk("xor_neg", 64'(out_neg), 64'd1);
      chk("xor_parity", 64'(out_parity), 64'd0);
      step();
      chk("xor_retired", 64'(retired), 64'(r0 + 16'd1));
      chk("xor_empty", 64'(out_valid), 64'd0);

      // Zero flag
      a = 64'hAAAA_AAAA_AAAA_AAAA;
      offer(a ^ a, 2'b10);
      step();
      in_valid = 1'b0;
      chk("zero_flag", 64'(out_zero), 64'd1);
      chk("zero_neg", 64'(out_neg), 64'd0);
      chk("zero_parity", 64'(out_parity), 64'd0);
      step();

      // Backpressure fills the buffer
      out_ready = 1'b0;
      offer(64'h1, 2'b01);
      step();
      offer(64'h3, 2'b00);
      step();
      in_valid = 1'b0;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_head", out_result, 64'h1);
`ifdef ALU_RESULT_STAGE_PARITY_EN
      chk("bp_par1", 64'(out_parity), 64'd1);
`else
      chk("bp_par1", 64'(out_parity), 64'd0);
`endif
      step();
      step();
      chk("bp_hold", out_result, 64'h1);
      out_ready = 1'b1;
      step();
      chk("bp_second", out_result, 64'h3);
      chk("bp_par2", 64'(out_parity), 64'd0);
      chk("bp_ready_back", 64'(in_ready), 64'd1);
      step();
      chk("bp_drained", 64'(out_valid), 64'd0);

      // Streaming back-to-back
      r0 = retired;
      for (int i = 0; i < 10; i++) begin
         offer(64'(i), 2'(i % 3));
         step();
         chk("stream_ready", 64'(in_ready), 64'd1);
         chk("stream_head", out_result, 64'(i));
      end
      in_valid = 1'b0;
      step();
      chk("stream_count", 64'(retired - r0), 64'd10);

      // Reserved opcode is consumed and flagged
      offer(64'h5, 2'b11);
      step();
      in_valid = 1'b0;
      chk("rsv_no_valid", 64'(out_valid), 64'd0);
      chk("rsv_err", 64'(err_op), 64'd1);
      step();
      step();
      chk("rsv_sticky", 64'(err_op), 64'd1);
      offer(64'h7, 2'b00);
      step();
      in_valid = 1'b0;
      chk("rsv_after_push", out_result, 64'h7);
      chk("rsv_after_valid", 64'(out_valid), 64'd1);
      step();

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         in_valid = 1'($urandom_range(0, 3) != 0);
         in_op    = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         case ($urandom_range(0, 3))
            0:       in_result = 64'd0;
            1:       in_result = {1'b1, 63'($urandom)};
            default: in_result = {$urandom, $urandom};
         endcase
         out_ready = 1'($urandom_range(0, 2) != 0);
         step();
      end
      in_valid = 1'b0;

      // Asynchronous reset with the buffer full
      out_ready = 1'b0;
      step();
      step();
      offer(64'h11, 2'b00);
      step();
      offer(64'h22, 2'b01);
      step();
      in_valid = 1'b0;
      chk("full_before_rst", 64'(in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_in_ready", 64'(in_ready), 64'd1);
      chk("async_out_valid", 64'(out_valid), 64'd0);
      chk("async_out_result", out_result, 64'd0);
      chk("async_err", 64'(err_op), 64'd0);
      chk("async_retired", 64'(retired), 64'd0);
      step();
      rst_n = 1'b1;
      step();

      // 17 pops: the 4-bit counter wraps to 1
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         offer(64'(100 + i), 2'b01);
         step();
      end
      in_valid = 1'b0;
      step();
      chk("wrap_retired4", 64'(retired_4), 64'd1);
      chk("wrap_retired16", 64'(retired), 64'd17);

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
